// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types, LFSR taps and address-window check for the bus memory model.
package mips_bus_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] base, input logic [31:0] bytes);
    logic [31:0] off;
    off = a - base;
    return a[1:0] == 2'b00 && off < bytes;
  endfunction
endpackage

// File: rtl/mips_bus_mem_model_lfsr.sv
// bus_wait_lfsr: 16-bit Fibonacci LFSR that steps once per wait-state draw.
module bus_wait_lfsr import mips_bus_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed_i,
  input  logic        advance_i,
  output logic [15:0] value_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= seed_i;
    else if (advance_i) lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  assign value_o = lfsr_q;
endmodule

// File: rtl/mips_bus_mem_model.sv
// mips_bus_mem_model: Avalon-MM slave RAM with byte-lane writes, wait-state stretching and transfer checking.
module mips_bus_mem_model import mips_bus_pkg::*; #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter int          WAIT_MODE   = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                err
);
  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(DEPTH);
  state_t state_q;
  logic [15:0] cnt_q, tgt_q, tgt_d, lfsr;
  logic [31:0] addr_q;
  logic rd_q, wr_q;
  logic [NB-1:0] be_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic req, idle, done, changed, bad, we;
  logic [IW-1:0] idx;
  bus_wait_lfsr u_lfsr (
    .clk(clk), .rst_n(reset), .seed_i(LFSR_SEED),
    .advance_i(idle && req), .value_o(lfsr)
  );
  assign req = read | write;
  assign idle = state_q == IDLE;
  assign tgt_d = WAIT_MODE != 0 ? 16'(32'(lfsr) % 32'(WAIT_CYCLES + 1)) : 16'(WAIT_CYCLES);
  // Outputs are forced quiet while reset is held so a mid-wait reset releases the master at once.
  assign waitrequest = reset & (idle ? req && tgt_d != 16'd0 : cnt_q != tgt_q);
  assign done = reset & req & ~waitrequest;
  assign changed = !idle && (address != addr_q || read != rd_q || write != wr_q ||
                             byteenable != be_q || writedata != wd_q);
  assign bad = !in_range(address, BASE_ADDR, 32'(4 * DEPTH)) || (read && write) || changed;
  assign idx = IW'((address - BASE_ADDR) >> 2);
  assign err = done & bad;
  assign we = done & write & ~bad;
  assign readdata = done && read && !bad ? mem[idx] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tgt_q <= '0;
      addr_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      be_q <= '0;
      wd_q <= '0;
    end else if (idle) begin
      if (req && tgt_d != 16'd0) begin
        state_q <= WAIT;
        tgt_q <= tgt_d;
        cnt_q <= 16'd1;
        addr_q <= address;
        rd_q <= read;
        wr_q <= write;
        be_q <= byteenable;
        wd_q <= writedata;
      end
    end else if (!req || !waitrequest) state_q <= IDLE;
    else cnt_q <= cnt_q + 16'd1;
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < NB; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
endmodule

// File: tb/tb_mips_bus_mem_model.sv
// tb_mips_bus_mem_model: three model instances (0 waits, 3 fixed, 0..5 random) checked against a reference model.
module tb_mips_bus_mem_model;
  localparam logic [31:0] B = 32'hBFC00000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rd [3], wr [3], wreq [3], err [3];
  logic [31:0] addr [3], wd [3], rdat [3];
  logic [3:0] be [3];
  int vectors = 0, miscompares = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic [31:0] mm [16];

  always #5 clk = ~clk;

  mips_bus_mem_model #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst_n), .address(addr[0]), .read(rd[0]),
    .write(wr[0]), .byteenable(be[0]), .writedata(wd[0]), .waitrequest(wreq[0]), .readdata(rdat[0]), .err(err[0]));
  mips_bus_mem_model #(.WAIT_CYCLES(3), .WAIT_MODE(0)) u3 (.clk(clk), .reset(rst_n), .address(addr[1]), .read(rd[1]),
    .write(wr[1]), .byteenable(be[1]), .writedata(wd[1]), .waitrequest(wreq[1]), .readdata(rdat[1]), .err(err[1]));
  mips_bus_mem_model #(.WAIT_CYCLES(5), .WAIT_MODE(1)) u5 (.clk(clk), .reset(rst_n), .address(addr[2]), .read(rd[2]),
    .write(wr[2]), .byteenable(be[2]), .writedata(wd[2]), .waitrequest(wreq[2]), .readdata(rdat[2]), .err(err[2]));

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic int draw(input int k);
    int w;
    if (k == 0) return 0;
    if (k == 1) return 3;
    w = int'(lfsr_m % 16'd6);
    lfsr_m = lfsr_nxt(lfsr_m);
    return w;
  endfunction

  task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] q, output logic e, output int n, output int ew);
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wd[k] = d;
    n = -1; q = '0; e = 1'b0;
    ew = draw(k);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!wreq[k]) begin q = rdat[k]; e = err[k]; n = c; end
      @(posedge clk); #1;
      if (n >= 0) break;
    end
    rd[k] = 1'b0; wr[k] = 1'b0;
    if (n < 0) begin vectors++; miscompares++; $display("FAIL timeout inst=%0d addr=%h", k, a); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin rd[k] = 1'b1; addr[k] = B; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (wreq[k] !== 1'b0 || rdat[k] !== 32'h0 || err[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs inst=%0d got wr=%b rd=%h err=%b want 0/0/0", k, wreq[k], rdat[k], err[k]);
      end
      rd[k] = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] q; logic e; int n, ew;
    xfer(0, 0, 1, B, 4'hF, 32'h8C030001, q, e, n, ew);
    vectors++;
    if (n !== ew || e !== 1'b0) begin miscompares++; $display("FAIL zw_write got n=%0d err=%b want n=%0d err=0", n, e, ew); end
    xfer(0, 1, 0, B, 4'h0, 32'h0, q, e, n, ew);
    vectors++;
    if (n !== 0 || q !== 32'h8C030001 || e !== 1'b0) begin
      miscompares++; $display("FAIL zw_read got n=%0d data=%h err=%b want 0/8c030001/0", n, q, e);
    end
  endtask

  task automatic test_fixed_wait();
    logic [31:0] q; logic e; int n, ew;
    xfer(1, 0, 1, B + 4, 4'hF, 32'h12345678, q, e, n, ew);
    vectors++;
    if (n !== 3 || e !== 1'b0) begin miscompares++; $display("FAIL fw_write got n=%0d err=%b want 3/0", n, e); end
    xfer(1, 1, 0, B + 4, 4'hF, 32'h0, q, e, n, ew);
    vectors++;
    if (n !== 3 || q !== 32'h12345678 || e !== 1'b0) begin
      miscompares++; $display("FAIL fw_read got n=%0d data=%h err=%b want 3/12345678/0", n, q, e);
    end
  endtask

  task automatic test_byteenable();
    logic [31:0] q; logic e; int n, ew;
    xfer(0, 0, 1, B + 8, 4'hF, 32'hAABBCCDD, q, e, n, ew);
    xfer(0, 0, 1, B + 8, 4'b0101, 32'h11223344, q, e, n, ew);
    xfer(0, 1, 0, B + 8, 4'h0, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'hAA22CC44 || e !== 1'b0) begin miscompares++; $display("FAIL be_merge got %h err=%b want aa22cc44/0", q, e); end
    xfer(0, 0, 1, B + 8, 4'h0, 32'hDEADBEEF, q, e, n, ew);
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL be_zero_err got %b want 0", e); end
    xfer(0, 1, 0, B + 8, 4'h0, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'hAA22CC44) begin miscompares++; $display("FAIL be_zero_data got %h want aa22cc44", q); end
  endtask

  task automatic test_errors();
    logic [31:0] bad_a [5];
    logic [31:0] q; logic e; int n, ew;
    bad_a[0] = 32'h00000001; bad_a[1] = 32'h00000000; bad_a[2] = B + 2;
    bad_a[3] = B + 32'd4096; bad_a[4] = B - 4;
    for (int i = 0; i < 5; i++) begin
      xfer(0, 1, 0, bad_a[i], 4'hF, 32'h0, q, e, n, ew);
      vectors++;
      if (q !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL err_read a=%h got %h/%b want 0/1", bad_a[i], q, e); end
      @(negedge clk);
      vectors++;
      if (err[0] !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle a=%h got %b want 0", bad_a[i], err[0]); end
      @(posedge clk); #1;
      xfer(0, 0, 1, bad_a[i], 4'hF, 32'h5555AAAA, q, e, n, ew);
      vectors++;
      if (e !== 1'b1) begin miscompares++; $display("FAIL err_write a=%h got %b want 1", bad_a[i], e); end
    end
    xfer(0, 1, 1, B + 8, 4'hF, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL err_rdwr got %h/%b want 0/1", q, e); end
    xfer(0, 1, 0, B, 4'h0, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'h8C030001) begin miscompares++; $display("FAIL err_nowrite0 got %h want 8c030001", q); end
    xfer(0, 1, 0, B + 8, 4'h0, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'hAA22CC44) begin miscompares++; $display("FAIL err_nowrite8 got %h want aa22cc44", q); end
  endtask

  task automatic test_abort();
    logic [31:0] q; logic e; int n, ew;
    rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = B + 4; be[1] = 4'hF; wd[1] = 32'hFFFFFFFF;
    @(negedge clk);
    vectors++;
    if (wreq[1] !== 1'b1) begin miscompares++; $display("FAIL abort_wait got %b want 1", wreq[1]); end
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (err[1] !== 1'b0) begin miscompares++; $display("FAIL abort_err got %b want 0", err[1]); end
    @(posedge clk); #1;
    xfer(1, 1, 0, B + 4, 4'hF, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'h12345678 || n !== 3) begin miscompares++; $display("FAIL abort_data got %h n=%0d want 12345678 n=3", q, n); end
  endtask

  task automatic test_random_wait();
    logic [31:0] q, d; logic e; int n, ew, w;
    logic [3:0] b;
    logic [31:0] m;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      xfer(2, 0, 1, B + 32'(4 * i), 4'hF, d, q, e, n, ew);
      mm[i] = d;
      vectors++;
      if (n !== ew || e !== 1'b0) begin miscompares++; $display("FAIL rnd_preload i=%0d got n=%0d err=%b want n=%0d err=0", i, n, e, ew); end
    end
    for (int t = 0; t < 200; t++) begin
      w = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom; b = 4'($urandom);
        xfer(2, 0, 1, B + 32'(4 * w), b, d, q, e, n, ew);
        m = mm[w];
        for (int l = 0; l < 4; l++) if (b[l]) m[8*l +: 8] = d[8*l +: 8];
        mm[w] = m;
        vectors++;
        if (n !== ew || e !== 1'b0) begin miscompares++; $display("FAIL rnd_write t=%0d got n=%0d err=%b want n=%0d err=0", t, n, e, ew); end
      end else begin
        xfer(2, 1, 0, B + 32'(4 * w), 4'($urandom), 32'($urandom), q, e, n, ew);
        vectors++;
        if (n !== ew || e !== 1'b0 || q !== mm[w]) begin
          miscompares++; $display("FAIL rnd_read t=%0d got n=%0d err=%b data=%h want n=%0d err=0 data=%h", t, n, e, q, ew, mm[w]);
        end
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] q; logic e; int n, ew, c;
    while (lfsr_m % 16'd6 == 16'd0) xfer(2, 1, 0, B, 4'hF, 32'h0, q, e, n, ew);
    ew = draw(2);
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = B; be[2] = 4'hF; wd[2] = ~mm[0];
    @(negedge clk);
    vectors++;
    if (wreq[2] !== 1'b1) begin miscompares++; $display("FAIL snap_wait got %b want 1 (draw %0d)", wreq[2], ew); end
    @(posedge clk); #1;
    addr[2] = B + 4;
    e = 1'b0; c = 0;
    for (c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!wreq[2]) begin e = err[2]; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (e !== 1'b1 || c >= 10) begin miscompares++; $display("FAIL snap_err got %b cycles=%0d want 1", e, c); end
    @(posedge clk); #1;
    wr[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xfer(2, 1, 0, B + 32'(4 * i), 4'hF, 32'h0, q, e, n, ew);
      vectors++;
      if (q !== mm[i] || n !== ew) begin miscompares++; $display("FAIL snap_nowrite i=%0d got %h n=%0d want %h n=%0d", i, q, n, mm[i], ew); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] q; logic e; int n, ew;
    rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = B + 4; be[1] = 4'hF; wd[1] = 32'h0BADF00D;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wreq[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid got wr=%b err=%b rd=%h want 0/0/0", wreq[1], err[1], rdat[1]);
    end
    wr[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lfsr_m = 16'hACE1;
    @(posedge clk); #1;
    xfer(1, 1, 0, B + 4, 4'hF, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== 32'h12345678 || n !== 3 || e !== 1'b0) begin
      miscompares++; $display("FAIL rst_nowrite got %h n=%0d err=%b want 12345678 n=3 err=0", q, n, e);
    end
    xfer(2, 1, 0, B + 12, 4'hF, 32'h0, q, e, n, ew);
    vectors++;
    if (q !== mm[3] || n !== ew) begin miscompares++; $display("FAIL rst_reseed got %h n=%0d want %h n=%0d", q, n, mm[3], ew); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; be[k] = '0; wd[k] = '0;
    end
    test_reset();
    test_zero_wait();
    test_fixed_wait();
    test_byteenable();
    test_errors();
    test_abort();
    test_random_wait();
    test_snapshot();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
